// File: rtl/sync_filter.sv
// Purpose : multi-channel async-input synchronizer with a per-channel persistence filter and edge pulses.
// Latency : STAGES + FILTER_LEN clock edges from a stable input change to out_o changing.
// Backpressure: none; free-running level path with no handshake.
//
// Ports:
//   clk      - sole clock, all state updates on its rising edge
//   rst_n    - asynchronous active-low reset; chains and out_o go to RST_VAL, counters and pulses to 0
//   in_i     - WIDTH asynchronous level inputs, one bit per channel
//   out_o    - WIDTH synchronized, filtered levels (registered)
//   rise_o   - one-cycle pulse per channel when out_o accepts a 0->1 change
//   fall_o   - one-cycle pulse per channel when out_o accepts a 1->0 change
//
// Build option: define SYNC_FILTER_EDGE_EN to generate the rise_o/fall_o registers.
// Without it both outputs are tied to 0 and out_o behaves identically.
module sync_filter #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      STAGES     = 2,
    parameter int unsigned      FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // A FILTER_LEN of 1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int unsigned      CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    // ------------------------------------------------------------------
    // Synchronizer chains: plain flop-to-flop, nothing between stages.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= in_i;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[STAGES-1];

    // ------------------------------------------------------------------
    // Persistence filter. The counter counts consecutive cycles where the
    // synchronized level disagrees with out; any agreement clears it, so a
    // glitch back to the current level throws away the partial count.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q <= out_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_o = out_q;

    // ------------------------------------------------------------------
    // Edge pulses. Derived from the next-state of out so the pulse register
    // updates on the same edge as out_q and is visible in the same cycle.
    // Reset forces both pulses low and out to RST_VAL together, so neither
    // reset entry nor exit can produce a pulse.
    // ------------------------------------------------------------------
`ifdef SYNC_FILTER_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Purpose : self-checking bench for sync_filter (WIDTH=4, STAGES=2, FILTER_LEN=3, RST_VAL=0).
// Latency : expectations are compared 1 time unit after each rising edge.
// Backpressure: n/a; every cycle produces one expected record popped from the scoreboard.
module tb_sync_filter;

`ifdef SYNC_FILTER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_v;
    logic [3:0] out_v;
    logic [3:0] rise_v;
    logic [3:0] fall_v;

    sync_filter #(
        .WIDTH      (4),
        .STAGES     (2),
        .FILTER_LEN (3),
        .RST_VAL    (4'b0000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (in_v),
        .out_o  (out_v),
        .rise_o (rise_v),
        .fall_o (fall_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    typedef struct {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        string      tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[21];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: two-stage input pipe, window of the last three
    // synchronized values seen by the filter, and the filtered level.
    logic [3:0] m_s0, m_s1, m_w0, m_w1, m_w2, m_out;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of input, queue its expectation, compare after the edge.
    task automatic drive_cycle(input logic [3:0] v, input logic [3:0] eo,
                               input logic [3:0] er, input logic [3:0] ef,
                               input string tag);
        exp_t e;
        in_v   = v;
        e.out  = eo;
        e.rise = EDGE_EN ? er : 4'b0000;
        e.fall = EDGE_EN ? ef : 4'b0000;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check4({e.tag, ".out"},  out_v,  e.out);
        check4({e.tag, ".rise"}, rise_v, e.rise);
        check4({e.tag, ".fall"}, fall_v, e.fall);
    endtask

    task automatic model_reset();
        m_s0  = 4'b0000;
        m_s1  = 4'b0000;
        m_w0  = 4'b0000;
        m_w1  = 4'b0000;
        m_w2  = 4'b0000;
        m_out = 4'b0000;
    endtask

    // out flips only when the last three synchronized samples all differ from it.
    task automatic model_cycle(input logic [3:0] v, input string tag);
        logic [3:0] mis;
        logic [3:0] nxt;
        m_w2  = m_w1;
        m_w1  = m_w0;
        m_w0  = m_s1;
        mis   = (m_w0 ^ m_out) & (m_w1 ^ m_out) & (m_w2 ^ m_out);
        nxt   = m_out ^ mis;
        m_out = nxt;
        m_s1  = m_s0;
        m_s0  = v;
        drive_cycle(v, nxt, mis & nxt, mis & ~nxt, tag);
    endtask

    // Assert reset between edges and check that state clears without a clock.
    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check4({tag, ".out_imm"},  out_v,  4'b0000);
        check4({tag, ".rise_imm"}, rise_v, 4'b0000);
        check4({tag, ".fall_imm"}, fall_v, 4'b0000);
        in_v = 4'b1111;
        @(posedge clk);
        #1;
        check4({tag, ".out_held"},  out_v,  4'b0000);
        check4({tag, ".rise_held"}, rise_v, 4'b0000);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        // edge-by-edge vectors: {in, expected out, expected rise, expected fall}
        tbl[0]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0101, 4'b0001, 4'b0001, 4'b0000};
        tbl[5]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0101, 4'b0101, 4'b0100, 4'b0000};
        tbl[8]  = '{4'b0101, 4'b0101, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1111, 4'b0101, 4'b0000, 4'b0000};
        tbl[10] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000};
        tbl[11] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000};
        tbl[13] = '{4'b1111, 4'b1111, 4'b1010, 4'b0000};
        tbl[14] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[16] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[17] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[18] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
        tbl[20] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

        // Power-on reset, held across a clock edge.
        rst_n = 1'b0;
        in_v  = 4'b0000;
        model_reset();
        #12;
        check4("por.out",  out_v,  4'b0000);
        check4("por.rise", rise_v, 4'b0000);
        check4("por.fall", fall_v, 4'b0000);
        #10 rst_n = 1'b1;

        // Directed table: single-channel rise, short pulse rejection,
        // interrupted count on ch2, then all-high and all-low transitions.
        for (int i = 0; i < 21; i++) begin
            drive_cycle(tbl[i].in, tbl[i].out, tbl[i].rise, tbl[i].fall,
                        $sformatf("tbl[%0d]", i));
        end

        // Reset between edges, then bring out high via the model.
        async_reset_check("rst_a");
        for (int i = 0; i < 5; i++) model_cycle(4'b1111, $sformatf("set_hi[%0d]", i));
        // Start a fall count and abort it with reset before acceptance.
        for (int i = 0; i < 4; i++) model_cycle(4'b0000, $sformatf("pend[%0d]", i));
        check4("pend.out_before_reset", out_v, 4'b1111);
        async_reset_check("rst_mid");
        // After release: no spurious pulse, then full latency to accept a change.
        for (int i = 0; i < 3; i++) model_cycle(4'b0000, $sformatf("post_rst_idle[%0d]", i));
        for (int i = 0; i < 6; i++) model_cycle(4'b1111, $sformatf("post_rst_rise[%0d]", i));

        // Random toggling with glitches of varying length on each channel.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] flip;
            flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            model_cycle(in_v ^ flip, $sformatf("rnd[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
